// File: rtl/multi_clock_gen.sv
// -----------------------------------------------------------------------------
// multi_clock_gen
//
// Multi-channel divided-clock / strobe generator. Each channel runs a small
// IDLE -> PHASE -> LOW -> HIGH state machine clocked by the system clock and
// emits a registered divided clock with matching rise/fall strobes. No
// generated clock drives a flop clock pin; everything lives in `clock`.
//
// Optional build macro:
//   MULTI_CLOCK_GEN_PERIOD_CNT_EN - adds period_cnt, a 16-bit per-channel rise
//                                   counter (wraps, cleared on start/reset).
//
// Parameters:
//   NUM_CH    - number of channels (1..16)
//   CNT_W     - width of low/high/phase counts
//   DEF_LOW   - reset value of the low-time registers
//   DEF_HIGH  - reset value of the high-time registers
//   DEF_PHASE - reset value of the phase registers
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   per-channel run request (level)
//   cfg_we     in   configuration write strobe
//   cfg_ch     in   channel addressed by a configuration write
//   cfg_low    in   low time in cycles (0 behaves as 1)
//   cfg_high   in   high time in cycles (0 behaves as 1)
//   cfg_phase  in   idle-low cycles before the first low phase (0 = none)
//   clk_out    out  generated clocks, registered
//   rise_stb   out  pulse in the first cycle clk_out is 1
//   fall_stb   out  pulse in the first cycle clk_out is back to 0
//   period_cnt out  per-channel rise counters (macro builds only)
//   busy       out  channel not idle
// -----------------------------------------------------------------------------
module multi_clock_gen #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DEF_LOW   = 4,
  parameter int unsigned DEF_HIGH  = 6,
  parameter int unsigned DEF_PHASE = 0,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enable,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_W-1:0]     cfg_low,
  input  logic [CNT_W-1:0]     cfg_high,
  input  logic [CNT_W-1:0]     cfg_phase,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    rise_stb,
  output logic [NUM_CH-1:0]    fall_stb,
`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
  output logic [NUM_CH*16-1:0] period_cnt,
`endif
  output logic [NUM_CH-1:0]    busy
);

  typedef enum logic [1:0] {
    StIdle,
    StPhase,
    StLow,
    StHigh
  } ch_state_e;

  localparam logic [CNT_W-1:0] DefLow   = CNT_W'(DEF_LOW);
  localparam logic [CNT_W-1:0] DefHigh  = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DefPhase = CNT_W'(DEF_PHASE);

  // Terminal value of an up-counter that spans v cycles; v=0 behaves as 1.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sh_low_q, sh_high_q, sh_phase_q;
    logic [CNT_W-1:0] act_low_q, act_high_q, act_phase_q;
    logic             load_act;
    logic             wr_sel;
    logic             clk_q, rise_q, fall_q, busy_q;
    logic             rise_d, fall_d;

    // Only an in-range cfg_ch can equal a channel index, so out-of-range
    // writes fall through without touching any channel.
    assign wr_sel = cfg_we && (32'(cfg_ch) == i);

    // Next-state logic. cnt_q counts cycles spent in the current state.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      load_act = 1'b0;
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (enable[i]) begin
            // Start uses the shadow values directly; active copies follow.
            load_act = 1'b1;
            state_d  = (sh_phase_q != '0) ? StPhase : StLow;
          end
        end
        StPhase: begin
          if (!enable[i]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == last_cnt(act_phase_q)) begin
            state_d = StLow;
            cnt_d   = '0;
          end
        end
        StLow: begin
          if (!enable[i]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == last_cnt(act_low_q)) begin
            state_d = StHigh;
            cnt_d   = '0;
          end
        end
        StHigh: begin
          // High time always completes so no runt high pulse is produced.
          if (cnt_q == last_cnt(act_high_q)) begin
            cnt_d = '0;
            if (enable[i]) begin
              state_d  = StLow;
              load_act = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    // Strobes are derived from the state transition so they register
    // together with clk_out.
    assign rise_d = (state_d == StHigh) && (state_q != StHigh);
    assign fall_d = (state_d != StHigh) && (state_q == StHigh);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        sh_low_q    <= DefLow;
        sh_high_q   <= DefHigh;
        sh_phase_q  <= DefPhase;
        act_low_q   <= DefLow;
        act_high_q  <= DefHigh;
        act_phase_q <= DefPhase;
        clk_q       <= 1'b0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (wr_sel) begin
          sh_low_q   <= cfg_low;
          sh_high_q  <= cfg_high;
          sh_phase_q <= cfg_phase;
        end
        // Reads the pre-write shadow, so a write landing on the same edge
        // as HIGH->LOW only takes effect one period later.
        if (load_act) begin
          act_low_q   <= sh_low_q;
          act_high_q  <= sh_high_q;
          act_phase_q <= sh_phase_q;
        end
        clk_q  <= (state_d == StHigh);
        rise_q <= rise_d;
        fall_q <= fall_d;
        busy_q <= (state_d != StIdle);
      end
    end

    assign clk_out[i]  = clk_q;
    assign rise_stb[i] = rise_q;
    assign fall_stb[i] = fall_q;
    assign busy[i]     = busy_q;

`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
    logic [15:0] pcnt_q;
    logic        start;

    assign start = (state_q == StIdle) && enable[i];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pcnt_q <= '0;
      end else if (start) begin
        pcnt_q <= '0;
      end else if (rise_d) begin
        pcnt_q <= pcnt_q + 16'd1;
      end
    end

    assign period_cnt[i*16 +: 16] = pcnt_q;
`endif
  end : g_ch

endmodule

// File: tb/tb_multi_clock_gen.sv
// Self-checking bench for multi_clock_gen: directed scenarios with fixed
// cycle expectations plus a randomized run against a segment-level model.
module tb_multi_clock_gen;

  localparam int NumCh     = 2;
  localparam int CntW      = 8;
  localparam int ChW       = 1;
  localparam int DefLow    = 4;
  localparam int DefHigh   = 6;
  localparam int DefPhase  = 0;
  localparam int ModeIdle  = 0;
  localparam int ModePhase = 1;
  localparam int ModeLow   = 2;
  localparam int ModeHigh  = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [NumCh-1:0] enable;
  logic             cfg_we;
  logic [ChW-1:0]   cfg_ch;
  logic [CntW-1:0]  cfg_low, cfg_high, cfg_phase;
  logic [NumCh-1:0] clk_out, rise_stb, fall_stb, busy;
`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
  logic [NumCh*16-1:0] period_cnt;
`endif

  multi_clock_gen #(
    .NUM_CH   (NumCh),
    .CNT_W    (CntW),
    .DEF_LOW  (DefLow),
    .DEF_HIGH (DefHigh),
    .DEF_PHASE(DefPhase)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_low  (cfg_low),
    .cfg_high (cfg_high),
    .cfg_phase(cfg_phase),
    .clk_out  (clk_out),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
    .period_cnt(period_cnt),
`endif
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a current segment plus cycles remaining.
  int m_mode[NumCh];
  int m_rem[NumCh];
  int m_al[NumCh], m_ah[NumCh], m_ap[NumCh];
  int m_sl[NumCh], m_sh[NumCh], m_sp[NumCh];
  int m_pc[NumCh];
  bit m_rise[NumCh], m_fall[NumCh];

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NumCh; ch++) begin
      m_mode[ch] = ModeIdle;
      m_rem[ch]  = 0;
      m_al[ch] = DefLow;  m_ah[ch] = DefHigh;  m_ap[ch] = DefPhase;
      m_sl[ch] = DefLow;  m_sh[ch] = DefHigh;  m_sp[ch] = DefPhase;
      m_pc[ch]   = 0;
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < NumCh; ch++) begin
      logic en;
      bit   was_high;
      en       = enable[ch];
      was_high = (m_mode[ch] == ModeHigh);
      case (m_mode[ch])
        ModeIdle: begin
          if (en) begin
            m_al[ch] = m_sl[ch];  m_ah[ch] = m_sh[ch];  m_ap[ch] = m_sp[ch];
            m_pc[ch] = 0;
            if (m_sp[ch] > 0) begin
              m_mode[ch] = ModePhase;
              m_rem[ch]  = m_sp[ch];
            end else begin
              m_mode[ch] = ModeLow;
              m_rem[ch]  = eff(m_sl[ch]);
            end
          end
        end
        ModePhase, ModeLow: begin
          if (!en) begin
            m_mode[ch] = ModeIdle;
          end else begin
            m_rem[ch]--;
            if (m_rem[ch] == 0) begin
              if (m_mode[ch] == ModePhase) begin
                m_mode[ch] = ModeLow;
                m_rem[ch]  = eff(m_al[ch]);
              end else begin
                m_mode[ch] = ModeHigh;
                m_rem[ch]  = eff(m_ah[ch]);
              end
            end
          end
        end
        default: begin
          m_rem[ch]--;
          if (m_rem[ch] == 0) begin
            if (en) begin
              m_al[ch] = m_sl[ch];  m_ah[ch] = m_sh[ch];  m_ap[ch] = m_sp[ch];
              m_mode[ch] = ModeLow;
              m_rem[ch]  = eff(m_al[ch]);
            end else begin
              m_mode[ch] = ModeIdle;
            end
          end
        end
      endcase
      m_rise[ch] = (m_mode[ch] == ModeHigh) && !was_high;
      m_fall[ch] = (m_mode[ch] != ModeHigh) && was_high;
      if (m_rise[ch]) m_pc[ch] = (m_pc[ch] + 1) & 16'hFFFF;
    end
    // Shadow write lands after the copy decision, as in hardware.
    if (cfg_we && int'(cfg_ch) < NumCh) begin
      m_sl[int'(cfg_ch)] = int'(cfg_low);
      m_sh[int'(cfg_ch)] = int'(cfg_high);
      m_sp[int'(cfg_ch)] = int'(cfg_phase);
    end
  endtask

  task automatic compare_model();
    for (int ch = 0; ch < NumCh; ch++) begin
      check_eq($sformatf("clk_out[%0d]", ch), 32'(clk_out[ch]), 32'(m_mode[ch] == ModeHigh));
      check_eq($sformatf("rise_stb[%0d]", ch), 32'(rise_stb[ch]), 32'(m_rise[ch]));
      check_eq($sformatf("fall_stb[%0d]", ch), 32'(fall_stb[ch]), 32'(m_fall[ch]));
      check_eq($sformatf("busy[%0d]", ch), 32'(busy[ch]), 32'(m_mode[ch] != ModeIdle));
`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
      check_eq($sformatf("period_cnt[%0d]", ch), 32'(period_cnt[ch*16 +: 16]), 32'(m_pc[ch]));
`endif
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg_write(input int ch, input int l, input int h, input int p);
    cfg_we    = 1'b1;
    cfg_ch    = ChW'(ch);
    cfg_low   = CntW'(l);
    cfg_high  = CntW'(h);
    cfg_phase = CntW'(p);
    tick();
    cfg_we    = 1'b0;
  endtask

  // Called at posedge+1: asserts reset with no clock edge in between.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst clk_out", 32'(clk_out), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst rise_stb", 32'(rise_stb), 32'd0);
    check_eq("rst fall_stb", 32'(fall_stb), 32'd0);
`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
    check_eq("rst period_cnt", 32'(period_cnt), 32'd0);
`endif
    model_reset();
    #3;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = '0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_low   = '0;
    cfg_high  = '0;
    cfg_phase = '0;
    model_reset();
    #12;
    check_eq("reset clk_out", 32'(clk_out), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    ticks(2);

    // Defaults on ch0: low 4, high 6.
    enable = 2'b01;
    for (int c = 1; c <= 26; c++) begin
      tick();
      check_eq($sformatf("dflt clk c%0d", c), 32'(clk_out[0]),
               32'((c >= 5 && c <= 10) || (c >= 15 && c <= 20) || c >= 25));
      check_eq($sformatf("dflt rise c%0d", c), 32'(rise_stb[0]), 32'(c == 5 || c == 15 || c == 25));
      check_eq($sformatf("dflt fall c%0d", c), 32'(fall_stb[0]), 32'(c == 11 || c == 21));
      check_eq($sformatf("dflt busy c%0d", c), 32'(busy[0]), 32'd1);
    end
    enable = '0;
    ticks(8);

    // ch1 L=2 H=3 P=5 alongside defaults on ch0.
    cfg_write(1, 2, 3, 5);
    enable = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check_eq($sformatf("ph rise1 c%0d", c), 32'(rise_stb[1]), 32'(c == 8 || c == 13 || c == 18));
      check_eq($sformatf("ph rise0 c%0d", c), 32'(rise_stb[0]), 32'(c == 5 || c == 15));
    end
    enable = '0;
    ticks(8);

    // L=H=0 behaves as 1: toggle every cycle.
    cfg_write(0, 0, 0, 0);
    enable = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_eq($sformatf("tog clk c%0d", c), 32'(clk_out[0]), 32'(c % 2 == 0));
      check_eq($sformatf("tog rise c%0d", c), 32'(rise_stb[0]), 32'(c % 2 == 0));
      check_eq($sformatf("tog fall c%0d", c), 32'(fall_stb[0]), 32'(c % 2 == 1 && c >= 3));
    end
    enable = '0;
    ticks(4);

    // Enable dropped in the 2nd high cycle: full high time still runs.
    cfg_write(0, 4, 6, 0);
    enable = 2'b01;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check_eq($sformatf("drop clk c%0d", c), 32'(clk_out[0]), 32'(c >= 5 && c <= 10));
      check_eq($sformatf("drop rise c%0d", c), 32'(rise_stb[0]), 32'(c == 5));
      check_eq($sformatf("drop fall c%0d", c), 32'(fall_stb[0]), 32'(c == 11));
      check_eq($sformatf("drop busy c%0d", c), 32'(busy[0]), 32'(c <= 10));
      if (c == 6) enable = 2'b00;
    end
    ticks(2);

    // L=8 written while running at L=4: next period becomes 14.
    enable = 2'b01;
    for (int c = 1; c <= 34; c++) begin
      tick();
      check_eq($sformatf("upd rise c%0d", c), 32'(rise_stb[0]), 32'(c == 5 || c == 19 || c == 33));
      if (c == 2) begin
        cfg_we = 1'b1;  cfg_ch = '0;  cfg_low = 8'd8;  cfg_high = 8'd6;  cfg_phase = 8'd0;
      end else begin
        cfg_we = 1'b0;
      end
    end
    enable = '0;
    ticks(16);

    // Three rises, then async reset in the middle of high.
    cfg_write(0, 4, 6, 0);
    enable = 2'b01;
    ticks(26);
    check_eq("mid-high clk", 32'(clk_out[0]), 32'd1);
`ifdef MULTI_CLOCK_GEN_PERIOD_CNT_EN
    check_eq("pcnt after 3 rises", 32'(period_cnt[15:0]), 32'd3);
`endif
    async_reset();
    enable = 2'b11;
    for (int c = 1; c <= 11; c++) begin
      tick();
      check_eq($sformatf("post-rst rise0 c%0d", c), 32'(rise_stb[0]), 32'(c == 5));
      check_eq($sformatf("post-rst rise1 c%0d", c), 32'(rise_stb[1]), 32'(c == 5));
    end

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        if ($urandom_range(0, 15) == 0) enable[ch] = ~enable[ch];
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_we    = 1'b1;
        cfg_ch    = ChW'($urandom_range(0, NumCh - 1));
        cfg_low   = CntW'($urandom_range(0, 6));
        cfg_high  = CntW'($urandom_range(0, 6));
        cfg_phase = CntW'($urandom_range(0, 4));
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      if (n == 1500) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
